// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and line/frame geometry from a raw hsync/vsync/de stream.
// Optional VGA_DEC_STATS_EN adds err_count_o, a saturating count of lock losses.
//
// state   | meaning
// SEARCH  | waiting for the first vsync leading edge; partial frame ignored
// MEASURE | capturing geometry each frame, counting consecutive matches
// LOCKED  | geometry stable; any mismatch or overflow drops lock
`timescale 1ns/1ps
module vga_sync_decoder #(
    parameter int HSZ         = 10,
    parameter int VSZ         = 10,
    parameter int SYNC_NEG    = 1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           hsync_i,
    input  logic           vsync_i,
    input  logic           de_i,
    output logic           de_o,
    output logic [HSZ-1:0] hcount_o,
    output logic [VSZ-1:0] vcount_o,
    output logic           line_start_o,
    output logic           frame_start_o,
    output logic [HSZ-1:0] htotal_o,
    output logic [HSZ-1:0] hactive_o,
    output logic [VSZ-1:0] vactive_o,
    output logic           locked_o,
    output logic           lock_lost_o
`ifdef VGA_DEC_STATS_EN
    ,
    output logic [15:0]    err_count_o
`endif
);

    localparam logic           POL     = (SYNC_NEG != 0);
    localparam int             MW      = $clog2(LOCK_FRAMES + 1);
    localparam logic [MW-1:0]  LOCK_N  = MW'(LOCK_FRAMES);
    localparam logic [HSZ-1:0] HMAX    = '1;
    localparam logic [HSZ-1:0] HMAX_M1 = {{(HSZ-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t         state;
    logic [MW-1:0]  match_cnt;
    logic           hs_r, vs_r, de_r, hs_p, vs_p, de_p;
    logic           hs_lead, vs_lead, de_rise, de_fall;
    logic [HSZ-1:0] h_cnt, h_line, a_cnt, a_line;
    logic [VSZ-1:0] v_cnt;
    logic           ovf_frame, ovf_evt;
    logic [HSZ-1:0] h_cap, a_cap;
    logic [VSZ-1:0] v_cap;
    logic           set_match, lost_evt;
    logic [MW-1:0]  match_inc;

    assign de_o = de_r;

    // Inputs are made active-high here; edges come from the registered copies.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hs_r <= 1'b0;
            vs_r <= 1'b0;
            de_r <= 1'b0;
            hs_p <= 1'b0;
            vs_p <= 1'b0;
            de_p <= 1'b0;
        end else begin
            hs_r <= hsync_i ^ POL;
            vs_r <= vsync_i ^ POL;
            de_r <= de_i;
            hs_p <= hs_r;
            vs_p <= vs_r;
            de_p <= de_r;
        end
    end

    assign hs_lead = hs_r & ~hs_p;
    assign vs_lead = vs_r & ~vs_p;
    assign de_rise = de_r & ~de_p;
    assign de_fall = ~de_r & de_p;

    // Coordinates are computed in the same stage as de_r so they line up with de_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcount_o     <= '0;
            vcount_o     <= '0;
            line_start_o <= 1'b0;
        end else begin
            line_start_o <= de_i & ~de_r;
            hcount_o     <= (de_i & de_r) ? hcount_o + HSZ'(1) : '0;
            if (vs_lead)
                vcount_o <= '0;
            else if (~de_i & de_r)
                vcount_o <= vcount_o + VSZ'(1);
        end
    end

    assign ovf_evt = ~hs_lead & (h_cnt == HMAX_M1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt     <= '0;
            h_line    <= '0;
            a_cnt     <= '0;
            a_line    <= '0;
            v_cnt     <= '0;
            ovf_frame <= 1'b0;
        end else begin
            if (hs_lead) begin
                h_cnt  <= HSZ'(1);
                h_line <= h_cnt;
            end else if (h_cnt != HMAX) begin
                h_cnt <= h_cnt + HSZ'(1);
            end
            if (de_rise)
                a_cnt <= HSZ'(1);
            else if (de_r && a_cnt != HMAX)
                a_cnt <= a_cnt + HSZ'(1);
            if (de_fall)
                a_line <= a_cnt;
            if (vs_lead) begin
                v_cnt     <= '0;
                ovf_frame <= ovf_evt;
            end else begin
                if (de_fall)
                    v_cnt <= v_cnt + VSZ'(1);
                if (ovf_evt)
                    ovf_frame <= 1'b1;
            end
        end
    end

    // A line or active run that ends on the vsync edge itself belongs to the closing frame.
    assign h_cap     = hs_lead ? h_cnt : h_line;
    assign a_cap     = de_fall ? a_cnt : a_line;
    assign v_cap     = v_cnt + VSZ'(de_fall);
    assign set_match = (h_cap == htotal_o) && (a_cap == hactive_o) && (v_cap == vactive_o)
                       && !ovf_frame && !ovf_evt;
    assign match_inc = (match_cnt == LOCK_N) ? LOCK_N : match_cnt + MW'(1);
    assign lost_evt  = (state == LOCKED) && (ovf_evt || (vs_lead && !set_match));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= SEARCH;
            match_cnt     <= '0;
            locked_o      <= 1'b0;
            lock_lost_o   <= 1'b0;
            frame_start_o <= 1'b0;
            htotal_o      <= '0;
            hactive_o     <= '0;
            vactive_o     <= '0;
        end else begin
            frame_start_o <= vs_lead;
            lock_lost_o   <= lost_evt;
            if (ovf_evt) begin
                state     <= SEARCH;
                match_cnt <= '0;
                locked_o  <= 1'b0;
            end else if (vs_lead) begin
                case (state)
                    SEARCH: begin
                        state     <= MEASURE;
                        match_cnt <= '0;
                    end
                    MEASURE: begin
                        htotal_o  <= h_cap;
                        hactive_o <= a_cap;
                        vactive_o <= v_cap;
                        if (set_match) begin
                            match_cnt <= match_inc;
                            if (match_inc == LOCK_N) begin
                                state    <= LOCKED;
                                locked_o <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        htotal_o  <= h_cap;
                        hactive_o <= a_cap;
                        vactive_o <= v_cap;
                        if (!set_match) begin
                            state     <= MEASURE;
                            match_cnt <= '0;
                            locked_o  <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= SEARCH;
                        match_cnt <= '0;
                        locked_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef VGA_DEC_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            err_count_o <= '0;
        else if (lost_evt && err_count_o != 16'hFFFF)
            err_count_o <= err_count_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down raster (40 clk lines, 20-line frames).
// Frame table drives geometry and lock expectations; a per-pixel queue checks coordinates.
`timescale 1ns/1ps
module tb_vga_sync_decoder;
    localparam int HSZ    = 10;
    localparam int VSZ    = 10;
    localparam int LINE   = 40;
    localparam int HSW    = 4;
    localparam int DE0    = 8;
    localparam int NLINES = 20;
    localparam int VBP    = 3;
    localparam int NFRM   = 17;

    logic           clk = 1'b0;
    logic           rst_i, hsync_i, vsync_i, de_i;
    logic           de_o, line_start_o, frame_start_o, locked_o, lock_lost_o;
    logic [HSZ-1:0] hcount_o, htotal_o, hactive_o;
    logic [VSZ-1:0] vcount_o, vactive_o;
`ifdef VGA_DEC_STATS_EN
    logic [15:0]    err_count_o;
`endif

    vga_sync_decoder #(.HSZ(HSZ), .VSZ(VSZ), .SYNC_NEG(1), .LOCK_FRAMES(2)) dut (
        .clk_i(clk), .rst_i(rst_i), .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i),
        .de_o(de_o), .hcount_o(hcount_o), .vcount_o(vcount_o),
        .line_start_o(line_start_o), .frame_start_o(frame_start_o),
        .htotal_o(htotal_o), .hactive_o(hactive_o), .vactive_o(vactive_o),
        .locked_o(locked_o), .lock_lost_o(lock_lost_o)
`ifdef VGA_DEC_STATS_EN
        , .err_count_o(err_count_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit en;
        bit de;
        int hc;
        int vc;
        bit ls;
    } pix_t;

    typedef struct {
        int hact;
        int vact;
        int eht;
        int eha;
        int eva;
        bit elock;
        bit elost;
    } frm_t;

    int   checks = 0;
    int   errors = 0;
    bit   pix_en = 1'b0;
    pix_t pix_q[$];
    frm_t frm_q[$];
    frm_t tbl[NFRM];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic frm_t mk(input int ha, input int va, input int eht, input int eha,
                                input int eva, input bit el, input bit elo);
        frm_t f;
        f.hact = ha; f.vact = va; f.eht = eht; f.eha = eha; f.eva = eva;
        f.elock = el; f.elost = elo;
        return f;
    endfunction

    // One pixel clock: drive inputs, queue the expected aligned outputs, check after the edge.
    task automatic step(input bit hs, input bit vs, input bit de, input int x, input int y);
        pix_t p;
        hsync_i = ~hs;
        vsync_i = ~vs;
        de_i    = de;
        p.en = pix_en;
        p.de = de;
        p.hc = de ? x - DE0 : 0;
        p.vc = y;
        p.ls = de && (x == DE0);
        pix_q.push_back(p);
        @(posedge clk);
        #1;
        p = pix_q.pop_front();
        if (p.en) begin
            chk("de_o", 32'(de_o), 32'(p.de));
            chk("hcount", 32'(hcount_o), 32'(p.hc));
            chk("line_start", 32'(line_start_o), 32'(p.ls));
            if (p.de)
                chk("vcount", 32'(vcount_o), 32'(p.vc));
        end
    endtask

    // Blank lines, active lines, blank lines, then two vsync lines whose leading
    // edge coincides with an hsync leading edge and closes the frame.
    task automatic drive_frame(input frm_t f);
        frm_t e;
        bit   act;
        bit   vsl;
        frm_q.push_back(f);
        for (int l = 0; l < NLINES; l++) begin
            act = (l >= VBP) && (l < VBP + f.vact);
            vsl = (l >= NLINES - 2);
            for (int x = 0; x < LINE; x++) begin
                step(x < HSW, vsl, act && (x >= DE0) && (x < DE0 + f.hact), x, l - VBP);
                if (l == NLINES - 2 && x == 1) begin
                    e = frm_q.pop_front();
                    chk("frame_start", 32'(frame_start_o), 32'd1);
                    chk("htotal", 32'(htotal_o), 32'(e.eht));
                    chk("hactive", 32'(hactive_o), 32'(e.eha));
                    chk("vactive", 32'(vactive_o), 32'(e.eva));
                    chk("locked", 32'(locked_o), 32'(e.elock));
                    chk("lock_lost", 32'(lock_lost_o), 32'(e.elost));
                    pix_en = 1'b1;
                end
                if (l == NLINES - 2 && x == 2) begin
                    chk("frame_start_width", 32'(frame_start_o), 32'd0);
                    chk("lock_lost_width", 32'(lock_lost_o), 32'd0);
                end
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_de_o"}, 32'(de_o), 32'd0);
        chk({tag, "_hcount"}, 32'(hcount_o), 32'd0);
        chk({tag, "_vcount"}, 32'(vcount_o), 32'd0);
        chk({tag, "_line_start"}, 32'(line_start_o), 32'd0);
        chk({tag, "_frame_start"}, 32'(frame_start_o), 32'd0);
        chk({tag, "_htotal"}, 32'(htotal_o), 32'd0);
        chk({tag, "_hactive"}, 32'(hactive_o), 32'd0);
        chk({tag, "_vactive"}, 32'(vactive_o), 32'd0);
        chk({tag, "_locked"}, 32'(locked_o), 32'd0);
        chk({tag, "_lock_lost"}, 32'(lock_lost_o), 32'd0);
`ifdef VGA_DEC_STATS_EN
        chk({tag, "_err_count"}, 32'(err_count_o), 32'd0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lost_cnt;
        int lost_at;

        // hact, vact, expected htotal/hactive/vactive, locked, lock_lost
        tbl[0]  = mk(24, 12,  0,  0,  0, 1'b0, 1'b0);
        tbl[1]  = mk(24, 12, 40, 24, 12, 1'b0, 1'b0);
        tbl[2]  = mk(24, 12, 40, 24, 12, 1'b0, 1'b0);
        tbl[3]  = mk(24, 12, 40, 24, 12, 1'b1, 1'b0);
        tbl[4]  = mk(24, 12, 40, 24, 12, 1'b1, 1'b0);
        tbl[5]  = mk(20, 12, 40, 20, 12, 1'b0, 1'b1);
        tbl[6]  = mk(24, 12, 40, 24, 12, 1'b0, 1'b0);
        tbl[7]  = mk(24, 12, 40, 24, 12, 1'b0, 1'b0);
        tbl[8]  = mk(24, 12, 40, 24, 12, 1'b1, 1'b0);
        tbl[9]  = mk(24, 11, 40, 24, 11, 1'b0, 1'b1);
        tbl[10] = mk(24, 12, 40, 24, 12, 1'b0, 1'b0);
        tbl[11] = mk(24, 12, 40, 24, 12, 1'b0, 1'b0);
        tbl[12] = mk(24, 12, 40, 24, 12, 1'b1, 1'b0);
        tbl[13] = mk(24, 12,  0,  0,  0, 1'b0, 1'b0);
        tbl[14] = mk(24, 12, 40, 24, 12, 1'b0, 1'b0);
        tbl[15] = mk(24, 12, 40, 24, 12, 1'b0, 1'b0);
        tbl[16] = mk(24, 12, 40, 24, 12, 1'b1, 1'b0);

        rst_i   = 1'b1;
        hsync_i = 1'b1;
        vsync_i = 1'b1;
        de_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_i = 1'b0;

        for (int i = 0; i <= 12; i++)
            drive_frame(tbl[i]);

        // Hsync stall while locked: counter saturates, lock drops exactly once.
        chk("locked_before_stall", 32'(locked_o), 32'd1);
        lost_cnt = 0;
        lost_at  = -1;
        for (int s = 0; s < 1100; s++) begin
            step(1'b0, 1'b0, 1'b0, 0, 0);
            if (lock_lost_o) begin
                lost_cnt++;
                if (lost_at < 0)
                    lost_at = s;
            end
        end
        chk("stall_lost_pulses", 32'(lost_cnt), 32'd1);
        chk("stall_locked", 32'(locked_o), 32'd0);
        checks++;
        if (lost_at < 980 || lost_at > 990) begin
            errors++;
            $display("FAIL stall_lost_time actual=%0d expected=980..990", lost_at);
        end
`ifdef VGA_DEC_STATS_EN
        chk("err_count_three", 32'(err_count_o), 32'd3);
`endif

        // One-cycle reset in the middle of an active line.
        pix_en = 1'b0;
        for (int x = 0; x < LINE; x++) begin
            if (x == 15)
                rst_i = 1'b1;
            step(x < HSW, 1'b0, (x >= DE0) && (x < DE0 + 24), x, 0);
            if (x == 15) begin
                rst_i = 1'b0;
                chk_zero("midline_rst");
            end
        end

        for (int i = 13; i < NFRM; i++)
            drive_frame(tbl[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
